// File: rtl/tetris_input_ctrl.sv
// rtl/tetris_input_ctrl.sv - joystick direction, auto-repeat and button debounce for the Tetris core
// Optional macro INPUT_HYSTERESIS_EN adds a hysteresis band around the direction thresholds.

module tetris_btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_n_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_n_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      if (sync2_q != db_n_q) begin
        // >= keeps the counter from ever running past its terminal value
        if (cnt_q >= CNT_LAST) begin
          db_n_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pressed = ~db_n_q;
endmodule

module tetris_input_ctrl #(
  parameter int ADC_W        = 12,
  parameter int LEFT_THRESH  = 1024,
  parameter int RIGHT_THRESH = 3072,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int DAS_DELAY    = 15_000_000,
  parameter int DAS_RATE     = 5_000_000,
  parameter int HYST         = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_x,
  input  logic             adc_valid,
  input  logic             btn_rotate_n,
  input  logic             btn_drop_n,
  output logic             move_left,
  output logic             move_right,
  output logic             rotate,
  output logic             move_down,
  output logic [1:0]       dir_state
);
  typedef enum logic [1:0] {DIR_CENTER = 2'd0, DIR_LEFT = 2'd1, DIR_RIGHT = 2'd2} dir_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_e;

`ifdef INPUT_HYSTERESIS_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam int RCNT_W = 24;
  localparam logic [ADC_W:0]    LT         = (ADC_W+1)'(LEFT_THRESH);
  localparam logic [ADC_W:0]    RT         = (ADC_W+1)'(RIGHT_THRESH);
  localparam logic [ADC_W:0]    LT_EXIT    = (ADC_W+1)'(LEFT_THRESH + HYST);
  localparam logic [ADC_W:0]    RT_EXIT    = (ADC_W+1)'(RIGHT_THRESH - HYST);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(DAS_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(DAS_RATE - 1);

  dir_e              dir_q, dir_d;
  dir_e              act_q, act_d;
  rep_state_e        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              left_q, left_d;
  logic              right_q, right_d;
  logic [ADC_W:0]    adc_ext;
  logic              rot_pressed;
  logic              rot_prev_q;

  assign adc_ext = {1'b0, adc_x};

  always_comb begin
    dir_d = dir_q;
    if (adc_valid) begin
      if (adc_ext < LT)      dir_d = DIR_LEFT;
      else if (adc_ext > RT) dir_d = DIR_RIGHT;
      else                   dir_d = DIR_CENTER;
      // inside the band an active direction is kept rather than re-classified
      if (HYST_EN && dir_q == DIR_LEFT && adc_ext < LT_EXIT)  dir_d = DIR_LEFT;
      if (HYST_EN && dir_q == DIR_RIGHT && adc_ext > RT_EXIT) dir_d = DIR_RIGHT;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    act_d   = act_q;
    left_d  = 1'b0;
    right_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (dir_q != DIR_CENTER) begin
        left_d  = (dir_q == DIR_LEFT);
        right_d = (dir_q == DIR_RIGHT);
        act_d   = dir_q;
        rcnt_d  = '0;
        state_d = ST_DELAY;
      end
    end else if (dir_q == DIR_CENTER) begin
      rcnt_d  = '0;
      state_d = ST_IDLE;
    end else if (dir_q != act_q) begin
      left_d  = (dir_q == DIR_LEFT);
      right_d = (dir_q == DIR_RIGHT);
      act_d   = dir_q;
      rcnt_d  = '0;
      state_d = ST_DELAY;
    end else if ((state_q == ST_DELAY && rcnt_q == DELAY_LAST) ||
                 (state_q == ST_REPEAT && rcnt_q == RATE_LAST)) begin
      left_d  = (act_q == DIR_LEFT);
      right_d = (act_q == DIR_RIGHT);
      rcnt_d  = '0;
      state_d = ST_REPEAT;
    end else if (rcnt_q != {RCNT_W{1'b1}}) begin
      rcnt_d = rcnt_q + RCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= DIR_CENTER;
      act_q      <= DIR_CENTER;
      state_q    <= ST_IDLE;
      rcnt_q     <= '0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      rot_prev_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      act_q      <= act_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      left_q     <= left_d;
      right_q    <= right_d;
      rot_prev_q <= rot_pressed;
    end
  end

  tetris_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_rotate (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_rotate_n),
    .pressed (rot_pressed)
  );

  tetris_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_drop (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_drop_n),
    .pressed (move_down)
  );

  assign move_left  = left_q;
  assign move_right = right_q;
  assign rotate     = rot_pressed & ~rot_prev_q;
  assign dir_state  = dir_q;
endmodule
